rvfi_commit_tracker: RTL and testbench
======================================

Name: rvfi_commit_tracker

Overview:
Parametrised commit-side monitor for the mp3 core.
- Accepts up to NCH retired instructions per cycle.
- Assigns each one a monotonically increasing RVFI order number.
- Detects program termination by a confirmed self-loop (jump-to-self) and by a no-commit watchdog.
- Sits between the core's retire stage and the RVFI monitor in the testbench top. It replaces the single-channel order counter and one-shot halt compare used there today.

Parameters:
NCH, 2, commit channels per cycle (1..4); channel 0 is oldest in program order
XLEN, 32, PC width
HALT_REPEAT, 2, consecutive self-loop commits required to declare halt (>=1)
TIMEOUT_CYCLES, 4096, commit-free cycles before timeout; 0 disables watchdog
CNT_W, 64, width of order counter and order outputs

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
commit_valid  in  NCH  per-channel retire strobe
commit_pc  in  NCH*XLEN  PC of retiring instruction, channel i at [i*XLEN +: XLEN]
commit_next_pc  in  NCH*XLEN  architectural next PC of that instruction
order_out  out  NCH*CNT_W  order number for channel i (combinational)
order_count  out  CNT_W  total instructions committed so far (registered)
halt  out  1  sticky: confirmed self-loop
timeout  out  1  sticky: watchdog expired
done  out  1  halt | timeout
stall_cycles  out  32  commit-free cycle count; see Optional Feature

Behaviour:
- Reset is asynchronous, active-high, on clk domain. On reset: state=RUN, order_count=0, loop_cnt=0, idle_cnt=0, halt=0, timeout=0, stall_cycles=0. Reset mid-operation (including from HALTED or TIMEOUT) returns to RUN immediately.
- States: RUN, HALTED, TIMEOUT. HALTED and TIMEOUT are terminal until reset.
- Order numbering, computed combinationally:
  - order_out[i] = order_count + popcount(commit_valid[i-1:0]).
  - Invalid channels still drive their computed value; the consumer ignores it.
  - Gaps in commit_valid are legal, e.g. valid=2'b10 gives channel 1 order_count+0.
- Counter update in RUN: order_count <= order_count + popcount(commit_valid). Wraps modulo 2^CNT_W with no flag.
- Self-loop classification, evaluated in RUN only, over valid channels only:
  - A channel is a self-loop when commit_next_pc == commit_pc.
  - If at least one channel is valid and all valid channels are self-loops: loop_cnt <= loop_cnt + (number of valid channels), saturating at HALT_REPEAT.
  - If any valid channel is not a self-loop: loop_cnt <= 0.
  - If no channel is valid: loop_cnt holds.
- Halt: when the next value of loop_cnt >= HALT_REPEAT, the state goes to HALTED on that edge and halt=1 from the next cycle. The commits in that cycle are still counted into order_count.
- Watchdog, active when TIMEOUT_CYCLES != 0, in RUN:
  - Any valid commit sets idle_cnt <= 0; otherwise idle_cnt <= idle_cnt + 1.
  - When idle_cnt == TIMEOUT_CYCLES-1 and no commit occurs, the state goes to TIMEOUT and timeout=1 the next cycle.
- Precedence: a commit always clears idle_cnt, so halt and timeout cannot trigger on the same edge. If both are somehow reachable, HALTED wins.
- In HALTED/TIMEOUT: order_count, loop_cnt and idle_cnt freeze, commit inputs are ignored, order_out still tracks the frozen order_count.
- done is combinational OR of the halt and timeout registers.
- No handshake back-pressure: the tracker never stalls the core.

Optional Feature:
Macro COMMIT_STALL_STATS_EN.
- Defined: stall_cycles is a 32-bit saturating register counting RUN-state cycles with commit_valid==0. It freezes in HALTED/TIMEOUT.
- Undefined: stall_cycles is tied to 0 and no counter logic is instantiated.
- No other behaviour changes.

Test Plan:
1. Reset, then commit_valid=2'b11 for 3 cycles with distinct PCs -> order_out pairs (0,1),(2,3),(4,5); order_count=6.
2. commit_valid=2'b10 with order_count=10 -> order_out[1]=10; order_count becomes 11.
3. HALT_REPEAT=2: channel 0 only, pc=next_pc=0x60 on two consecutive cycles -> halt=1 on the cycle after the second commit; order_count grows by 2; later commits are ignored.
4. Self-loop at 0x60, then a normal commit 0x64->0x68, then a self-loop again -> loop_cnt resets after the normal commit and halt stays 0 after the third commit.
5. TIMEOUT_CYCLES=8: one commit, then 8 idle cycles -> timeout=1 and done=1 on the 9th cycle after the commit; with COMMIT_STALL_STATS_EN, stall_cycles=8.
6. Assert rst for one cycle while in HALTED with order_count=37 -> halt=0, order_count=0 asynchronously; the next commit gets order 0.

Source files
------------

// File: rtl/rvfi_commit_tracker.sv
// Commit-side RVFI monitor: per-channel order numbering plus self-loop halt and watchdog timeout.
// Optional stall statistics are enabled by defining COMMIT_STALL_STATS_EN.
module rvfi_commit_tracker #(
  parameter int NCH            = 2,
  parameter int XLEN           = 32,
  parameter int HALT_REPEAT    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        commit_valid,
  input  logic [NCH*XLEN-1:0]   commit_pc,
  input  logic [NCH*XLEN-1:0]   commit_next_pc,
  output logic [NCH*CNT_W-1:0]  order_out,
  output logic [CNT_W-1:0]      order_count,
  output logic                  halt,
  output logic                  timeout,
  output logic                  done,
  output logic [31:0]           stall_cycles
);

  localparam int PW = $clog2(NCH + 1);
  localparam int LW = $clog2(HALT_REPEAT + NCH + 1);
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [LW-1:0] HALT_LIM  = LW'(HALT_REPEAT);

  typedef enum logic [1:0] {RUN, HALTED, TIMEOUT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] order_count_q, order_count_d;
  logic [LW-1:0]    loop_cnt_q, loop_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [PW-1:0]    prefix [NCH+1];
  logic [NCH-1:0]   is_loop;
  logic [LW-1:0]    loop_sum;
  logic             any_valid, all_loop, timeout_hit;

  // prefix[i] counts valid channels older than channel i; prefix[NCH] is the cycle total
  always_comb begin
    prefix[0] = '0;
    for (int i = 0; i < NCH; i++) begin
      prefix[i+1] = prefix[i] + PW'(commit_valid[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign is_loop[gi] = commit_next_pc[gi*XLEN +: XLEN] == commit_pc[gi*XLEN +: XLEN];
      assign order_out[gi*CNT_W +: CNT_W] = order_count_q + CNT_W'(prefix[gi]);
    end
  endgenerate

  assign any_valid = |commit_valid;
  assign all_loop  = &(is_loop | ~commit_valid);
  assign loop_sum  = loop_cnt_q + LW'(prefix[NCH]);

  always_comb begin
    state_d       = state_q;
    order_count_d = order_count_q;
    loop_cnt_d    = loop_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_hit   = 1'b0;
    if (state_q == RUN) begin
      order_count_d = order_count_q + CNT_W'(prefix[NCH]);
      if (any_valid) begin
        if (all_loop) loop_cnt_d = (loop_sum >= HALT_LIM) ? HALT_LIM : loop_sum;
        else          loop_cnt_d = '0;
      end
      if (TIMEOUT_CYCLES != 0) begin
        idle_cnt_d  = any_valid ? '0 : idle_cnt_q + 1'b1;
        timeout_hit = !any_valid && (idle_cnt_q == IDLE_LAST);
      end
      // Halt takes priority should both ever fire together
      if (loop_cnt_d >= HALT_LIM) state_d = HALTED;
      else if (timeout_hit)       state_d = TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      order_count_q <= '0;
      loop_cnt_q    <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      order_count_q <= order_count_d;
      loop_cnt_q    <= loop_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

`ifdef COMMIT_STALL_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == RUN && !any_valid && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  assign order_count = order_count_q;
  assign halt        = (state_q == HALTED);
  assign timeout     = (state_q == TIMEOUT);
  assign done        = halt | timeout;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed bench for rvfi_commit_tracker (NCH=2, HALT_REPEAT=2, TIMEOUT_CYCLES=8).
module tb_rvfi_commit_tracker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   commit_valid = '0;
  logic [63:0]  commit_pc = '0;
  logic [63:0]  commit_next_pc = '0;
  logic [127:0] order_out;
  logic [63:0]  order_count;
  logic         halt, timeout, done;
  logic [31:0]  stall_cycles;

  int checks = 0;
  int failures = 0;

  rvfi_commit_tracker #(
    .NCH(2), .XLEN(32), .HALT_REPEAT(2), .TIMEOUT_CYCLES(8), .CNT_W(64)
  ) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_next_pc(commit_next_pc), .order_out(order_out), .order_count(order_count),
    .halt(halt), .timeout(timeout), .done(done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] n0,
                       input logic [31:0] p1, input logic [31:0] n1);
    commit_valid   = v;
    commit_pc      = {p1, p0};
    commit_next_pc = {n1, n0};
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_order_count", order_count, 0);
    chk("reset_halt", halt, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_done", done, 0);
    chk("reset_stall", stall_cycles, 0);
    rst = 1'b0;

    // Three dual commits with distinct PCs
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h100 + 16*k, 32'h104 + 16*k, 32'h104 + 16*k, 32'h108 + 16*k);
      chk("dual_order0", order_out[63:0], 2*k);
      chk("dual_order1", order_out[127:64], 2*k + 1);
      tick();
      $display("txn dual k=%0d order_count=%0d", k, order_count);
    end
    chk("dual_count", order_count, 6);

    drive(2'b11, 32'h200, 32'h204, 32'h204, 32'h208); tick();
    drive(2'b11, 32'h208, 32'h20c, 32'h20c, 32'h210); tick();
    chk("count_10", order_count, 10);

    // Gap in valid: channel 1 only
    drive(2'b10, 32'h300, 32'h300, 32'h304, 32'h308);
    chk("gap_order1", order_out[127:64], 10);
    chk("gap_order0", order_out[63:0], 10);
    tick();
    $display("txn gap order_count=%0d", order_count);
    chk("gap_count", order_count, 11);

    // Self-loop interrupted by a normal commit never halts
    drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h4); tick();
    drive(2'b01, 32'h64, 32'h68, 32'h0, 32'h4); tick();
    drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h4); tick();
    $display("txn loop_break order_count=%0d halt=%0d", order_count, halt);
    chk("loop_break_halt", halt, 0);
    chk("loop_break_count", order_count, 14);

    // Advance to 35, then two consecutive self-loops
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 32'h400 + 16*k, 32'h404 + 16*k, 32'h404 + 16*k, 32'h408 + 16*k);
      tick();
    end
    drive(2'b01, 32'h500, 32'h504, 32'h0, 32'h4); tick();
    chk("pre_halt_count", order_count, 35);
    drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h4); tick();
    chk("first_loop_halt", halt, 0);
    drive(2'b01, 32'h60, 32'h60, 32'h0, 32'h4); tick();
    $display("txn halt order_count=%0d halt=%0d", order_count, halt);
    chk("halt_set", halt, 1);
    chk("halt_done", done, 1);
    chk("halt_count", order_count, 37);

    // Commits ignored once halted, order_out tracks frozen count
    drive(2'b11, 32'h600, 32'h604, 32'h604, 32'h608);
    chk("halted_order0", order_out[63:0], 37);
    chk("halted_order1", order_out[127:64], 38);
    tick();
    chk("halted_count", order_count, 37);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (10) tick();
    chk("halted_no_timeout", timeout, 0);
    chk("halted_sticky", halt, 1);

    // Asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    $display("txn async_reset order_count=%0d halt=%0d", order_count, halt);
    chk("arst_halt", halt, 0);
    chk("arst_count", order_count, 0);
    chk("arst_done", done, 0);
    tick();
    rst = 1'b0;

    // Single commit then watchdog
    drive(2'b01, 32'h700, 32'h704, 32'h0, 32'h4);
    chk("post_reset_order0", order_out[63:0], 0);
    tick();
    chk("post_reset_count", order_count, 1);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (7) tick();
    chk("idle7_timeout", timeout, 0);
    tick();
    $display("txn timeout order_count=%0d timeout=%0d stall=%0d", order_count, timeout, stall_cycles);
    chk("timeout_set", timeout, 1);
    chk("timeout_done", done, 1);
    chk("timeout_halt", halt, 0);
`ifdef COMMIT_STALL_STATS_EN
    chk("stall_8", stall_cycles, 8);
`else
    chk("stall_tied", stall_cycles, 0);
`endif
    drive(2'b11, 32'h800, 32'h804, 32'h804, 32'h808);
    tick();
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("timeout_frozen_count", order_count, 1);
    chk("timeout_sticky", timeout, 1);
`ifdef COMMIT_STALL_STATS_EN
    chk("stall_frozen", stall_cycles, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
